io_mailbox: RTL and testbench
=============================

# io_mailbox

Memory-mapped responder on the CPU data bus (same load/store signalling the CPU drives into data memory) that exchanges Q1.30 fixed-point samples with an external host. Host samples enter an RX FIFO through a valid/ready handshake and are popped by CPU loads; CPU stores push results into a TX FIFO that drains to the host through a second valid/ready handshake. It sits beside the data memory; the integrator muxes `rdata` on `hit`.

## Interface
- `BASE` default 32'h0000_0100: word-aligned base of the 16-byte register window (bits [3:0] ignored).
- `DEPTH` default 4: entries per FIFO, power of two, 2..16.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `addr` in 32: CPU data address.
- `wdata` in 32: CPU store data.
- `lw_en` in 1: load strobe, one cycle per load.
- `sw_en` in 1: store strobe, one cycle per store.
- `rdata` out 32: load data, combinational from `addr`/state.
- `hit` out 1: `addr[31:4]==BASE[31:4]`, combinational.
- `in_valid` in 1 / `in_ready` out 1: host→CPU handshake.
- `in_int` in 1 / `in_frac` in 30: host sample, integer and fraction bits.
- `out_valid` out 1 / `out_ready` in 1: CPU→host handshake.
- `out_int` out 1 / `out_frac` out 30: result sample, integer and fraction bits.

## Operation
- Sample word format: `{1'b0, int, frac[29:0]}`; on store, `wdata[31]` ignored, `wdata[30]`→int, `wdata[29:0]`→frac.
- Register map (offset = `addr[3:2]`), accesses ignored unless `hit`:
  - 0 STATUS (RO): [0] rx_nonempty, [1] tx_full, [2] rx_underflow sticky, [3] tx_overflow sticky, [8+:5] rx_count, [16+:5] tx_count, rest 0.
  - 1 RX_DATA (RO): head of RX FIFO; a load pops it. Load when empty returns 0, sets rx_underflow, no pop.
  - 2 TX_DATA (WO, reads 0): store pushes. Store when full is dropped, sets tx_overflow.
  - 3 CTRL (reads 0): store with `wdata[0]=1` flushes both FIFOs (counts→0, pointers→0) and clears both sticky bits; `wdata[0]=0` no effect.
- Loads of non-RX offsets and stores to RO offsets: no side effects. `rdata`=0 when `!hit`.
- `lw_en` and `sw_en` are never asserted together; if they are, store takes effect and load has no side effect.
- RX push: `in_valid && in_ready`; `in_ready = (rx_count != DEPTH)`, registered-count based (not relaxed by same-cycle pop).
- TX pop: `out_valid && out_ready`; `out_valid = (tx_count != 0)`; `out_int/out_frac` show TX head, held stable while `out_valid && !out_ready`.
- Simultaneous push and pop on one FIFO: both occur, count unchanged; allowed when empty only for push side (pop of empty never occurs since empty RX pop is rejected, TX pop gated by `out_valid`).
- CTRL flush in the same cycle as a host push/pop: flush wins; host transfer is discarded (host sees handshake completed).
- Pointers wrap modulo `DEPTH`; counts are `$clog2(DEPTH)+1` bits.

## Timing
- Reset: all pointers/counts 0, sticky bits 0; so `in_ready=1`, `out_valid=0`, `out_int=0`, `out_frac=0`, STATUS=0.
- Load data: combinational, valid in the same cycle as `lw_en`; pop takes effect at that clock edge.
- Host push at edge N → visible at RX_DATA / rx_nonempty in cycle N+1.
- CPU store to TX_DATA at edge N → `out_valid=1` in cycle N+1.
- Full throughput: one push and one pop per FIFO per cycle.
- Reset mid-operation discards all FIFO contents; no partial transfer survives.

## Test plan
- Reset then idle: STATUS reads 0, `in_ready=1`, `out_valid=0`, loads of RX_DATA return 0 and set STATUS[2] → STATUS=32'h4.
- Host pushes 32'h4000_0000 (int=1,frac=0) and 32'h2AAA_AAAA; CPU loads RX_DATA twice → returns 32'h4000_0000 then 32'h2AAA_AAAA, STATUS rx_count 2→1→0.
- Host pushes DEPTH=4 samples without CPU reads → `in_ready=0` after 4th; 5th held by host; after one RX pop, `in_ready=1` next cycle and 5th accepted, order preserved.
- CPU stores 32'hC000_0001 to TX_DATA with `out_ready=0` → `out_valid=1`, `out_int=1`, `out_frac=1` held 5 cycles; raise `out_ready` → `out_valid=0` next cycle.
- Five TX stores with `out_ready=0` → 5th dropped, STATUS[3]=1, tx_count=4; CTRL store 1 → STATUS=0, `out_valid=0`.
- Simultaneous host push and CPU pop with rx_count=2 → count stays 2, data order intact; `rst` asserted with both FIFOs non-empty → all outputs at reset values next cycle.

Source files
------------

// File: rtl/io_mailbox.sv
// CPU-bus mailbox: RX FIFO (host->CPU, popped by loads) and TX FIFO (CPU stores -> host).
// Loads are combinational. RX pops and TX pushes occur at the load/store edge. Host backpressure uses the valid/ready handshakes.
`timescale 1ns/1ps
module io_mailbox #(
  parameter logic [31:0] BASE  = 32'h0000_0100,
  parameter int          DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        lw_en,
  input  logic        sw_en,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_int,
  input  logic [29:0] in_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_int,
  output logic [29:0] out_frac
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [30:0]   rx_mem [DEPTH];
  logic [30:0]   tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_uf, tx_of;

  logic [1:0]  off;
  logic        ld, st, rx_push, rx_pop, rx_uf_set;
  logic        tx_push_req, tx_push, tx_pop, tx_of_set, flush;
  logic        rx_ne, tx_full;
  logic [31:0] status;

  assign hit  = (addr[31:4] == BASE[31:4]);
  assign off  = addr[3:2];
  // A store wins over a simultaneous load, so the load is stripped of side effects.
  assign st   = sw_en && hit;
  assign ld   = lw_en && !sw_en && hit;

  assign rx_ne   = (rx_count != '0);
  assign tx_full = (tx_count == FULL);

  assign in_ready  = (rx_count != FULL);
  assign out_valid = (tx_count != '0);

  assign rx_push     = in_valid && in_ready;
  assign rx_pop      = ld && (off == 2'd1) && rx_ne;
  assign rx_uf_set   = ld && (off == 2'd1) && !rx_ne;
  assign tx_push_req = st && (off == 2'd2);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_of_set   = tx_push_req && tx_full;
  assign tx_pop      = out_valid && out_ready;
  assign flush       = st && (off == 2'd3) && wdata[0];

  assign status = {11'b0, 5'(tx_count), 3'b0, 5'(rx_count), 4'b0,
                   tx_of, rx_uf, tx_full, rx_ne};

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        2'd0:    rdata = status;
        2'd1:    if (rx_ne) rdata = {1'b0, rx_mem[rx_rp]};
        default: rdata = '0;
      endcase
    end
  end

  // Head is gated so the host-facing sample reads 0 whenever the FIFO is empty.
  assign {out_int, out_frac} = out_valid ? tx_mem[tx_rp] : 31'd0;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= {in_int, in_frac};
    if (tx_push) tx_mem[tx_wp] <= wdata[30:0];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      tx_wp    <= '0;
      tx_rp    <= '0;
      rx_count <= '0;
      tx_count <= '0;
      rx_uf    <= 1'b0;
      tx_of    <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      if (rx_uf_set) rx_uf <= 1'b1;
      if (tx_of_set) tx_of <= 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31]};

endmodule

// File: tb/tb_io_mailbox.sv
// Directed bench for io_mailbox: register map, FIFO order, full/empty boundaries, flush and reset.
`timescale 1ns/1ps
module tb_io_mailbox;

  localparam logic [31:0] A_STAT = 32'h0000_0100;
  localparam logic [31:0] A_RX   = 32'h0000_0104;
  localparam logic [31:0] A_TX   = 32'h0000_0108;
  localparam logic [31:0] A_CTRL = 32'h0000_010C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        lw_en, sw_en, hit;
  logic        in_valid, in_ready, in_int;
  logic [29:0] in_frac;
  logic        out_valid, out_ready, out_int;
  logic [29:0] out_frac;

  int checks = 0;
  int failures = 0;
  logic [31:0] d;

  io_mailbox dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .lw_en(lw_en), .sw_en(sw_en),
    .rdata(rdata), .hit(hit), .in_valid(in_valid), .in_ready(in_ready),
    .in_int(in_int), .in_frac(in_frac), .out_valid(out_valid), .out_ready(out_ready),
    .out_int(out_int), .out_frac(out_frac)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input logic [31:0] exp);
    addr = A_STAT;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] data);
    addr  = a;
    lw_en = 1'b1;
    #1;
    data = rdata;
    tick();
    lw_en = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] data);
    addr  = a;
    wdata = data;
    sw_en = 1'b1;
    tick();
    sw_en = 1'b0;
  endtask

  task automatic host_set(input logic [31:0] w);
    in_int  = w[30];
    in_frac = w[29:0];
  endtask

  task automatic host_push(input logic [31:0] w);
    host_set(w);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    chk("push_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = A_STAT; wdata = '0; lw_en = 0; sw_en = 0;
    in_valid = 0; in_int = 0; in_frac = '0; out_ready = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    status("reset_status", 32'h0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_sample", {1'b0, out_int, out_frac}, 32'd0);

    addr = 32'h0000_0200;
    #1;
    chk("miss_hit", {31'b0, hit}, 32'd0);
    chk("miss_rdata", rdata, 32'd0);

    // Underflow
    load(A_RX, d);
    chk("rx_empty_data", d, 32'd0);
    status("underflow_status", 32'h4);
    store(A_CTRL, 32'h1);
    status("flush_clear_uf", 32'h0);

    // Basic RX order
    host_push(32'h4000_0000);
    host_push(32'h2AAA_AAAA);
    status("rx_two", 32'h0000_0201);
    load(A_RX, d);
    chk("rx_first", d, 32'h4000_0000);
    status("rx_one", 32'h0000_0101);
    load(A_RX, d);
    chk("rx_second", d, 32'h2AAA_AAAA);
    status("rx_zero", 32'h0);

    // Fill RX, hold fifth sample, pop one
    for (int i = 1; i <= 4; i++) host_push(32'(i));
    chk("rx_full_ready", {31'b0, in_ready}, 32'd0);
    host_set(32'd5);
    in_valid = 1'b1;
    tick(); tick();
    chk("rx_held_ready", {31'b0, in_ready}, 32'd0);
    status("rx_full_status", 32'h0000_0401);
    load(A_RX, d);
    chk("rx_full_pop", d, 32'd1);
    chk("rx_ready_after_pop", {31'b0, in_ready}, 32'd1);
    status("rx_three", 32'h0000_0301);
    tick();
    in_valid = 1'b0;
    status("rx_refull", 32'h0000_0401);
    for (int i = 2; i <= 5; i++) begin
      load(A_RX, d);
      chk("rx_order", d, 32'(i));
    end
    status("rx_drained", 32'h0);

    // TX hold under backpressure
    store(A_TX, 32'hC000_0001);
    for (int i = 0; i < 5; i++) begin
      chk("tx_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("tx_hold_sample", {1'b0, out_int, out_frac}, 32'h4000_0001);
      tick();
    end
    addr = A_TX;
    #1;
    chk("tx_reads_zero", rdata, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("tx_drained_valid", {31'b0, out_valid}, 32'd0);

    // TX overflow, CTRL no-op then flush
    for (int i = 1; i <= 5; i++) store(A_TX, 32'(i));
    status("tx_overflow", 32'h0004_000A);
    chk("tx_head", {1'b0, out_int, out_frac}, 32'd1);
    store(A_CTRL, 32'h0);
    status("ctrl_noop", 32'h0004_000A);
    store(A_CTRL, 32'h1);
    status("ctrl_flush", 32'h0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);

    // Simultaneous push and pop
    host_push(32'h11);
    host_push(32'h22);
    host_set(32'h33);
    in_valid = 1'b1;
    load(A_RX, d);
    in_valid = 1'b0;
    chk("simul_pop", d, 32'h11);
    status("simul_count", 32'h0000_0201);
    load(A_RX, d);
    chk("simul_next", d, 32'h22);
    load(A_RX, d);
    chk("simul_last", d, 32'h33);

    // Reset with both FIFOs occupied
    host_push(32'h77);
    store(A_TX, 32'h99);
    status("pre_reset", 32'h0001_0101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    status("post_reset_status", 32'h0);
    chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_reset_sample", {1'b0, out_int, out_frac}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
